score_log_sequencer: RTL and testbench

Sequences the shared 8x13-bit register file for the reaction game.
- Owns its single write port and its Q read address.
- Logs each accepted score into a ring of history slots and keeps register 0 as the run counter.
- Tracks the best (lowest) reaction time and scans history slots out to the score display.
- Sits between the round FSM (score producer), the register file and the seven-segment decoders.

---
 rtl/score_log_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_score_log_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_log_sequencer.sv
// Write/read sequencer for the reaction-game 8-word register file: clears it, logs scores,
// counts runs, tracks the best time and drives the display read address.
// Optional build macro SCORE_LOG_BEST_SLOT_EN reserves address 7 for the best score.
module score_log_sequencer #(
  parameter int SCORE_W    = 13,
  parameter int NUM_SLOTS  = 7,
  parameter int SCAN_TICKS = 500
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               ScoreValid,
  input  logic [SCORE_W-1:0] ScoreIn,
  output logic               ScoreReady,
  input  logic               ClearLog,
  input  logic               DisplayTick,
  input  logic               ScanEnable,
  output logic [2:0]         RegWA,
  output logic [SCORE_W-1:0] RegLoadData,
  output logic               RegLoad,
  output logic [2:0]         RegRQ,
  output logic [SCORE_W-1:0] RunCount,
  output logic [SCORE_W-1:0] BestScore,
  output logic               BestValid,
  output logic               Busy
);

`ifdef SCORE_LOG_BEST_SLOT_EN
  localparam int HIST_SLOTS = (NUM_SLOTS > 6) ? 6 : NUM_SLOTS;
  typedef enum logic [2:0] {CLEAR, IDLE, WR_SCORE, WR_COUNT, WR_BEST} state_t;
`else
  localparam int HIST_SLOTS = (NUM_SLOTS > 7) ? 7 : NUM_SLOTS;
  typedef enum logic [2:0] {CLEAR, IDLE, WR_SCORE, WR_COUNT} state_t;
`endif

  localparam logic [2:0] LAST_SLOT = 3'(HIST_SLOTS);
  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  state_t             state_q, state_d;
  logic [2:0]         clrIdx_q, clrIdx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         wptr_q, wptr_d;
  logic [2:0]         filled_q, filled_d;
  logic [SCORE_W-1:0] runCount_q, runCount_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               bestValid_q, bestValid_d;
  logic [2:0]         scanIdx_q, scanIdx_d;
  logic [TW-1:0]      tickCnt_q, tickCnt_d;
`ifdef SCORE_LOG_BEST_SLOT_EN
  logic               improved_q, improved_d;
`endif

  logic [SCORE_W-1:0] runInc;
  logic [2:0]         latestSlot;

  assign runInc     = (runCount_q == '1) ? runCount_q : runCount_q + 1'b1;
  assign latestSlot = (wptr_q == 3'd1) ? LAST_SLOT : wptr_q - 3'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= CLEAR;
      clrIdx_q    <= 3'd0;
      score_q     <= '0;
      wptr_q      <= 3'd1;
      filled_q    <= 3'd0;
      runCount_q  <= '0;
      best_q      <= '1;
      bestValid_q <= 1'b0;
      scanIdx_q   <= 3'd1;
      tickCnt_q   <= '0;
`ifdef SCORE_LOG_BEST_SLOT_EN
      improved_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clrIdx_q    <= clrIdx_d;
      score_q     <= score_d;
      wptr_q      <= wptr_d;
      filled_q    <= filled_d;
      runCount_q  <= runCount_d;
      best_q      <= best_d;
      bestValid_q <= bestValid_d;
      scanIdx_q   <= scanIdx_d;
      tickCnt_q   <= tickCnt_d;
`ifdef SCORE_LOG_BEST_SLOT_EN
      improved_q  <= improved_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    clrIdx_d    = clrIdx_q;
    score_d     = score_q;
    wptr_d      = wptr_q;
    filled_d    = filled_q;
    runCount_d  = runCount_q;
    best_d      = best_q;
    bestValid_d = bestValid_q;
`ifdef SCORE_LOG_BEST_SLOT_EN
    improved_d  = improved_q;
`endif
    RegLoad     = 1'b0;
    RegWA       = 3'd0;
    RegLoadData = '0;
    ScoreReady  = 1'b0;

    case (state_q)
      CLEAR: begin
        RegLoad  = 1'b1;
        RegWA    = clrIdx_q;
        clrIdx_d = clrIdx_q + 3'd1;
        if (clrIdx_q == 3'd7) state_d = IDLE;
      end
      IDLE: begin
        ScoreReady = !ClearLog;
        if (ClearLog) begin
          state_d  = CLEAR;
          clrIdx_d = 3'd0;
        end else if (ScoreValid) begin
          score_d = ScoreIn;
          state_d = WR_SCORE;
        end
      end
      WR_SCORE: begin
        RegLoad     = 1'b1;
        RegWA       = wptr_q;
        RegLoadData = score_q;
        wptr_d      = (wptr_q == LAST_SLOT) ? 3'd1 : wptr_q + 3'd1;
        filled_d    = (filled_q < LAST_SLOT) ? filled_q + 3'd1 : filled_q;
        bestValid_d = 1'b1;
        if (!bestValid_q || score_q < best_q) best_d = score_q;
`ifdef SCORE_LOG_BEST_SLOT_EN
        improved_d  = !bestValid_q || score_q < best_q;
`endif
        state_d     = WR_COUNT;
      end
      WR_COUNT: begin
        RegLoad     = 1'b1;
        RegWA       = 3'd0;
        RegLoadData = runInc;
        runCount_d  = runInc;
`ifdef SCORE_LOG_BEST_SLOT_EN
        state_d     = improved_q ? WR_BEST : IDLE;
`else
        state_d     = IDLE;
`endif
      end
`ifdef SCORE_LOG_BEST_SLOT_EN
      WR_BEST: begin
        RegLoad     = 1'b1;
        RegWA       = 3'd7;
        RegLoadData = best_q;
        state_d     = IDLE;
      end
`endif
      default: begin
        state_d  = CLEAR;
        clrIdx_d = 3'd0;
      end
    endcase

    // Log state is wiped on entry to CLEAR so it reads as cleared for the whole sequence.
    if (state_d == CLEAR) begin
      runCount_d  = '0;
      best_d      = '1;
      bestValid_d = 1'b0;
      filled_d    = 3'd0;
      wptr_d      = 3'd1;
    end

    // Reset gates the write port so an abandoned write never reaches the register file.
    if (Reset) begin
      RegLoad     = 1'b0;
      RegWA       = 3'd0;
      RegLoadData = '0;
      ScoreReady  = 1'b0;
    end
  end

  // Scan position idles at slot 1 with a zero tick count whenever scanning is off or the log is empty.
  always_comb begin
    scanIdx_d = scanIdx_q;
    tickCnt_d = tickCnt_q;
    if (!ScanEnable || filled_q == 3'd0) begin
      scanIdx_d = 3'd1;
      tickCnt_d = '0;
    end else if (DisplayTick) begin
      if (tickCnt_q == TICK_LAST) begin
        tickCnt_d = '0;
        scanIdx_d = (scanIdx_q >= filled_q) ? 3'd1 : scanIdx_q + 3'd1;
      end else begin
        tickCnt_d = tickCnt_q + 1'b1;
      end
    end
  end

  assign RegRQ     = (Reset || filled_q == 3'd0) ? 3'd1 : (ScanEnable ? scanIdx_q : latestSlot);
  assign RunCount  = runCount_q;
  assign BestScore = best_q;
  assign BestValid = bestValid_q;
  assign Busy      = Reset || (state_q != IDLE);

endmodule

// File: tb/tb_score_log_sequencer.sv
// Self-checking bench for score_log_sequencer: a transaction-level log model predicts every
// register-file write and the visible run/best state; directed vectors pin the model.
module tb_score_log_sequencer;

  localparam int SW = 13;
  localparam int ST = 2;
`ifdef SCORE_LOG_BEST_SLOT_EN
  localparam int HIST = 6;
  localparam bit BESTSLOT = 1'b1;
`else
  localparam int HIST = 7;
  localparam bit BESTSLOT = 1'b0;
`endif
  localparam int MAXRUN = 8191;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ScoreValid = 1'b0;
  logic [SW-1:0] ScoreIn = '0;
  logic          ClearLog = 1'b0;
  logic          DisplayTick = 1'b0;
  logic          ScanEnable = 1'b0;
  logic          ScoreReady;
  logic [2:0]    RegWA;
  logic [SW-1:0] RegLoadData;
  logic          RegLoad;
  logic [2:0]    RegRQ;
  logic [SW-1:0] RunCount;
  logic [SW-1:0] BestScore;
  logic          BestValid;
  logic          Busy;

  score_log_sequencer #(.SCORE_W(SW), .NUM_SLOTS(7), .SCAN_TICKS(ST)) dut (
    .Clock(Clock), .Reset(Reset), .ScoreValid(ScoreValid), .ScoreIn(ScoreIn),
    .ScoreReady(ScoreReady), .ClearLog(ClearLog), .DisplayTick(DisplayTick),
    .ScanEnable(ScanEnable), .RegWA(RegWA), .RegLoadData(RegLoadData), .RegLoad(RegLoad),
    .RegRQ(RegRQ), .RunCount(RunCount), .BestScore(BestScore), .BestValid(BestValid),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  typedef struct { int wa; int data; } wr_t;
  wr_t expQ[$];

  // Log model: history write pointer, fill level, run count and best time.
  int mRun = 0;
  int mBest = MAXRUN;
  bit mBestValid = 1'b0;
  int mWptr = 1;
  int mFilled = 0;
  bit lastImproved = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int latestSlot();
    if (mFilled == 0) return 1;
    return (mWptr == 1) ? HIST : mWptr - 1;
  endfunction

  function automatic void modelClear();
    mRun = 0;
    mBest = MAXRUN;
    mBestValid = 1'b0;
    mWptr = 1;
    mFilled = 0;
    expQ.delete();
    for (int i = 0; i < 8; i++) expQ.push_back('{i, 0});
  endfunction

  function automatic void modelAccept(input int score);
    lastImproved = !mBestValid || score < mBest;
    expQ.push_back('{mWptr, score});
    mWptr = (mWptr == HIST) ? 1 : mWptr + 1;
    if (mFilled < HIST) mFilled++;
    if (lastImproved) mBest = score;
    mBestValid = 1'b1;
    if (mRun < MAXRUN) mRun++;
    expQ.push_back('{0, mRun});
    if (BESTSLOT && lastImproved) expQ.push_back('{7, mBest});
  endfunction

  // Every write is matched in order against the model; steady state is compared whenever idle.
  always @(negedge Clock) begin
    if (!Reset) begin
      if (RegLoad) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected write", RegLoad, 0);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("write WA", RegWA, e.wa);
          checkOutput("write data", RegLoadData, e.data);
        end
      end
      if (!Busy) begin
        checkOutput("RunCount", RunCount, mRun);
        checkOutput("BestScore", BestScore, mBest);
        checkOutput("BestValid", BestValid, mBestValid);
      end
      if (!ClearLog) checkOutput("ready vs busy", ScoreReady, !Busy);
    end
  end

  task automatic waitReady(input string name, input int expected);
    int lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (!ScoreReady && lat < 30);
    checkOutput(name, lat, expected);
    @(posedge Clock);
    #1;
  endtask

  task automatic doHandshake(input int score);
    int n = 0;
    ScoreValid = 1'b1;
    ScoreIn = SW'(score);
    do begin
      @(negedge Clock);
      n++;
    end while (!ScoreReady && n < 30);
    checkOutput("handshake ready", ScoreReady, 1);
    if (!ScoreReady) begin
      ScoreValid = 1'b0;
      return;
    end
    @(posedge Clock);
    modelAccept(score);
    #1;
    ScoreValid = 1'b0;
    ScoreIn = '1;
  endtask

  task automatic applyStimulus(input int score);
    doHandshake(score);
    waitReady("accept latency", (BESTSLOT && lastImproved) ? 4 : 3);
  endtask

  task automatic applyClear(input bit withValid);
    ClearLog = 1'b1;
    ScoreValid = withValid;
    ScoreIn = SW'(999);
    @(negedge Clock);
    checkOutput("ready under clear", ScoreReady, 0);
    @(posedge Clock);
    modelClear();
    #1;
    ClearLog = 1'b0;
    ScoreValid = 1'b0;
    waitReady("clear length", 9);
    checkOutput("clear RegRQ", RegRQ, 1);
  endtask

  task automatic streamScores(input int count, input int score);
    int done = 0;
    int guard = 0;
    ScoreValid = 1'b1;
    ScoreIn = SW'(score);
    while (done < count && guard < count * 4 + 10) begin
      @(negedge Clock);
      guard++;
      if (ScoreReady) begin
        @(posedge Clock);
        modelAccept(score);
        done++;
      end
    end
    checkOutput("stream accepted", done, count);
    #1;
    ScoreValid = 1'b0;
    waitReady("stream tail", (BESTSLOT && lastImproved) ? 4 : 3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while Reset is held.
    @(posedge Clock);
    #1;
    @(negedge Clock);
    checkOutput("rst RegLoad", RegLoad, 0);
    checkOutput("rst RegWA", RegWA, 0);
    checkOutput("rst ScoreReady", ScoreReady, 0);
    checkOutput("rst Busy", Busy, 1);
    checkOutput("rst RegRQ", RegRQ, 1);
    checkOutput("rst RunCount", RunCount, 0);
    checkOutput("rst BestScore", BestScore, MAXRUN);
    checkOutput("rst BestValid", BestValid, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    modelClear();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      checkOutput("clear RegLoad", RegLoad, 1);
      checkOutput("clear RegWA", RegWA, i);
      checkOutput("clear data", RegLoadData, 0);
      checkOutput("clear ready", ScoreReady, 0);
    end
    @(negedge Clock);
    checkOutput("post-clear ready", ScoreReady, 1);
    checkOutput("post-clear BestValid", BestValid, 0);
    @(posedge Clock);
    #1;

    // First score and best tracking.
    applyStimulus(250);
    checkOutput("lit RunCount 1", RunCount, 1);
    checkOutput("lit Best 250", BestScore, 250);
    checkOutput("lit BestValid", BestValid, 1);
    checkOutput("lit latest 1", RegRQ, 1);
    applyStimulus(300);
    applyStimulus(180);
    checkOutput("lit Best 180", BestScore, 180);
    applyStimulus(180);
    applyStimulus(400);
    checkOutput("lit Best kept 180", BestScore, 180);
    checkOutput("lit RunCount 5", RunCount, 5);
    checkOutput("lit latest 5", RegRQ, 5);

    // ClearLog beats a simultaneous ScoreValid.
    applyClear(1'b1);
    checkOutput("lit cleared run", RunCount, 0);
    checkOutput("lit cleared valid", BestValid, 0);

    // Eight scores wrap the history and fill every slot.
    applyStimulus(100);
    applyStimulus(90);
    applyStimulus(95);
    applyStimulus(120);
    applyStimulus(80);
    applyStimulus(130);
    applyStimulus(140);
    applyStimulus(85);
    checkOutput("lit RunCount 8", RunCount, 8);
    checkOutput("lit Best 80", BestScore, 80);
    checkOutput("latest after wrap", RegRQ, latestSlot());

    // Scan rotates over filled slots, two ticks per slot.
    ScanEnable = 1'b1;
    for (int s = 0; s <= HIST; s++) begin
      @(negedge Clock);
      checkOutput("scan slot", RegRQ, (s % HIST) + 1);
      DisplayTick = 1'b1;
      @(negedge Clock);
      DisplayTick = 1'b0;
      checkOutput("scan hold", RegRQ, (s % HIST) + 1);
      DisplayTick = 1'b1;
      @(negedge Clock);
      DisplayTick = 1'b0;
    end
    ScanEnable = 1'b0;
    @(negedge Clock);
    checkOutput("scan off latest", RegRQ, latestSlot());
    @(posedge Clock);
    #1;

`ifdef SCORE_LOG_BEST_SLOT_EN
    applyClear(1'b0);
    doHandshake(500);
    waitReady("best slot lat 500", 4);
    doHandshake(200);
    waitReady("best slot lat 200", 4);
    doHandshake(600);
    waitReady("no best slot lat 600", 3);
    applyStimulus(700);
    applyStimulus(800);
    applyStimulus(900);
    applyStimulus(1000);
    checkOutput("lit slot6 wrap", RegRQ, 1);
    checkOutput("lit Best 200", BestScore, 200);
`endif

    // Reset during WR_COUNT abandons the count write and restarts CLEAR at 0.
    doHandshake(77);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    expQ.delete();
    @(negedge Clock);
    checkOutput("no count write on reset", RegLoad, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    modelClear();
    @(negedge Clock);
    checkOutput("restart clear load", RegLoad, 1);
    checkOutput("restart clear idx", RegWA, 0);
    waitReady("restart clear length", 8);
    checkOutput("lit reset run", RunCount, 0);

    // Run counter saturates rather than wrapping.
    streamScores(MAXRUN + 1, 1000);
    checkOutput("lit RunCount sat", RunCount, MAXRUN);

    checkOutput("pending writes", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
